mmc1_mapper: RTL and testbench

//  MMC1 (iNES mapper 1) bank controller between CPU/PPU buses and cart PRG/CHR ROM BRAMs.
//  - Decodes CPU writes to $8000-$FFFF through a 5-bit serial shift register into four

---
 rtl/mmc1_mapper.sv | 164 ++++++++++++++++
 tb/tb_mmc1_mapper.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmc1_mapper.sv
`default_nettype none
// ============================================================================
// Module   : mmc1_mapper
// Purpose  : MMC1 (iNES mapper 1) bank controller. CPU writes to $8000-$FFFF
//            are collected through a 5-bit serial shift register. Each
//            completed value is committed into one of four config registers:
//            control, chr0, chr1 or prg. The registers drive banked PRG/CHR
//            ROM addresses and the CIRAM mirroring/enable signals.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   PRG_AW    PRG ROM byte-address width (16 KB bank bits = PRG_AW-14, 1..4)
//   CHR_AW    CHR ROM byte-address width (4 KB bank bits = CHR_AW-12, 1..5)
//   WR_GUARD  cycles after an accepted write during which new writes drop
// Ports
//   clk_sys        in   system clock, rising edge
//   rst_n          in   synchronous reset, active low
//   prg_nce_in     in   CPU $8000-$FFFF select, active low
//   prg_a_in       in   CPU address [14:0]
//   prg_r_nw_in    in   CPU read(1)/write(0)
//   prg_d_in       in   CPU write data
//   chr_a_in       in   PPU address [13:0]
//   prg_rom_a_out  out  banked PRG ROM address
//   chr_rom_a_out  out  banked CHR ROM address
//   ciram_nce_out  out  CIRAM enable, active low
//   ciram_a10_out  out  CIRAM A10 (mirroring)
//   prg_ram_en_out out  PRG-RAM enable, active high
// Configuration macro
//   MMC1_CONSEC_GUARD_EN  when defined, write edges that arrive within
//                         WR_GUARD cycles of an accepted write are ignored
// ============================================================================
module mmc1_mapper #(
    parameter int PRG_AW   = 18,
    parameter int CHR_AW   = 17,
    parameter int WR_GUARD = 4
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              prg_nce_in,
    input  logic [14:0]       prg_a_in,
    input  logic              prg_r_nw_in,
    input  logic [7:0]        prg_d_in,
    input  logic [13:0]       chr_a_in,
    output logic [PRG_AW-1:0] prg_rom_a_out,
    output logic [CHR_AW-1:0] chr_rom_a_out,
    output logic              ciram_nce_out,
    output logic              ciram_a10_out,
    output logic              prg_ram_en_out
);

    localparam int c_PRG_BB = PRG_AW - 14;
    localparam int c_CHR_BB = CHR_AW - 12;

    logic [4:0] r_shift;
    logic [2:0] r_shift_cnt;
    logic [4:0] r_ctrl;
    logic [4:0] r_chr0;
    logic [4:0] r_chr1;
    logic [4:0] r_prg;
    logic       r_wr_prev;

    logic       w_wr;
    logic       w_accept;
    logic       w_guard_idle;
    logic [4:0] w_shift_next;
    logic [3:0] w_prg_bank;
    logic [4:0] w_chr_bank;
    logic       w_unused_d;

    assign w_wr     = ~prg_nce_in & ~prg_r_nw_in;
    // A held strobe counts once: only its rising edge is a write.
    assign w_accept = w_wr & ~r_wr_prev & w_guard_idle;
    // LSB-first: new bit enters at the top. After five bits the first one
    // has reached bit 0, so this is both the next shift and the commit value.
    assign w_shift_next = {prg_d_in[0], r_shift[4:1]};
    assign w_unused_d   = &{1'b0, prg_d_in[6:1]};

`ifdef MMC1_CONSEC_GUARD_EN
    localparam int c_GW = (WR_GUARD < 1) ? 1 : $clog2(WR_GUARD + 1);
    localparam logic [c_GW-1:0] c_GUARD_LOAD = c_GW'(WR_GUARD);

    logic [c_GW-1:0] r_guard;

    // Read-modify-write instructions hit the bus twice in a row; the
    // hold-off makes the second write of such a pair invisible.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_guard <= '0;
        end else if (w_accept) begin
            r_guard <= c_GUARD_LOAD;
        end else if (r_guard != '0) begin
            r_guard <= r_guard - 1'b1;
        end
    end

    assign w_guard_idle = (r_guard == '0);
`else
    assign w_guard_idle = 1'b1;
`endif

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_shift     <= 5'd0;
            r_shift_cnt <= 3'd0;
            r_ctrl      <= 5'h0C;
            r_chr0      <= 5'd0;
            r_chr1      <= 5'd0;
            r_prg       <= 5'd0;
            r_wr_prev   <= 1'b0;
        end else begin
            r_wr_prev <= w_wr;
            if (w_accept) begin
                if (prg_d_in[7]) begin
                    // Reset write: drop partial value, force fixed-last PRG mode.
                    r_shift     <= 5'd0;
                    r_shift_cnt <= 3'd0;
                    r_ctrl      <= r_ctrl | 5'h0C;
                end else if (r_shift_cnt == 3'd4) begin
                    r_shift     <= 5'd0;
                    r_shift_cnt <= 3'd0;
                    case (prg_a_in[14:13])
                        2'd0:    r_ctrl <= w_shift_next;
                        2'd1:    r_chr0 <= w_shift_next;
                        2'd2:    r_chr1 <= w_shift_next;
                        default: r_prg  <= w_shift_next;
                    endcase
                end else begin
                    r_shift     <= w_shift_next;
                    r_shift_cnt <= r_shift_cnt + 3'd1;
                end
            end
        end
    end

    always_comb begin
        w_prg_bank = 4'd0;
        case (r_ctrl[3:2])
            2'd2:    w_prg_bank = prg_a_in[14] ? r_prg[3:0] : 4'd0;
            2'd3:    w_prg_bank = prg_a_in[14] ? 4'hF : r_prg[3:0];
            default: w_prg_bank = {r_prg[3:1], prg_a_in[14]};
        endcase
    end

    assign w_chr_bank = r_ctrl[4] ? (chr_a_in[12] ? r_chr1 : r_chr0)
                                  : {r_chr0[4:1], chr_a_in[12]};

    always_comb begin
        ciram_a10_out = 1'b0;
        case (r_ctrl[1:0])
            2'd0:    ciram_a10_out = 1'b0;
            2'd1:    ciram_a10_out = 1'b1;
            2'd2:    ciram_a10_out = chr_a_in[10];
            default: ciram_a10_out = chr_a_in[11];
        endcase
    end

    // Upper bank bits beyond the ROM size are dropped, so small ROMs wrap.
    assign prg_rom_a_out  = {w_prg_bank[c_PRG_BB-1:0], prg_a_in[13:0]};
    assign chr_rom_a_out  = {w_chr_bank[c_CHR_BB-1:0], chr_a_in[11:0]};
    assign ciram_nce_out  = ~chr_a_in[13];
    assign prg_ram_en_out = ~r_prg[4];

endmodule
`default_nettype wire

// File: tb/tb_mmc1_mapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmc1_mapper
// Purpose  : Self-checking bench for mmc1_mapper. A register-level model
//            (bit queue, cycle-stamped write hold-off) predicts every output
//            each cycle; directed sequences pin the model with literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmc1_mapper;

    localparam int PRG_AW   = 18;
    localparam int CHR_AW   = 17;
    localparam int WR_GUARD = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              nce = 1'b1;
    logic              rnw = 1'b1;
    logic [14:0]       prg_a = '0;
    logic [7:0]        d = '0;
    logic [13:0]       chr_a = '0;
    logic [PRG_AW-1:0] prg_rom_a;
    logic [CHR_AW-1:0] chr_rom_a;
    logic              ciram_nce;
    logic              ciram_a10;
    logic              ram_en;

    mmc1_mapper #(.PRG_AW(PRG_AW), .CHR_AW(CHR_AW), .WR_GUARD(WR_GUARD)) dut (
        .clk_sys       (clk),
        .rst_n         (rst_n),
        .prg_nce_in    (nce),
        .prg_a_in      (prg_a),
        .prg_r_nw_in   (rnw),
        .prg_d_in      (d),
        .chr_a_in      (chr_a),
        .prg_rom_a_out (prg_rom_a),
        .chr_rom_a_out (chr_rom_a),
        .ciram_nce_out (ciram_nce),
        .ciram_a10_out (ciram_a10),
        .prg_ram_en_out(ram_en)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    int  m_ctrl, m_chr0, m_chr1, m_prg;
    int  m_bits[$];
    bit  m_prev;
    int  cyc = 0;
    int  last_acc = -1000;
    bit  started = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
        started = 1;
        if (!rst_n) begin
            m_ctrl = 12; m_chr0 = 0; m_chr1 = 0; m_prg = 0;
            m_bits.delete();
            m_prev = 0;
            last_acc = -1000;
        end else begin
            bit w;
            bit ok;
            int v;
            w  = !nce && !rnw;
            ok = 1;
`ifdef MMC1_CONSEC_GUARD_EN
            ok = (cyc - last_acc) > WR_GUARD;
`endif
            if (w && !m_prev && ok) begin
                last_acc = cyc;
                if (d[7]) begin
                    m_bits.delete();
                    m_ctrl = m_ctrl | 12;
                end else begin
                    m_bits.push_back(int'(d[0]));
                    if (m_bits.size() == 5) begin
                        v = 0;
                        foreach (m_bits[i]) v += m_bits[i] << i;
                        case (int'(prg_a[14:13]))
                            0: m_ctrl = v;
                            1: m_chr0 = v;
                            2: m_chr1 = v;
                            default: m_prg = v;
                        endcase
                        m_bits.delete();
                    end
                end
            end
            m_prev = w;
        end
    end

    function automatic int exp_prg();
        int mode, hi, bank;
        mode = (m_ctrl >> 2) & 3;
        hi   = int'(prg_a[14]);
        if (mode < 2)       bank = (m_prg & 14) | hi;
        else if (mode == 2) bank = hi ? (m_prg & 15) : 0;
        else                bank = hi ? 15 : (m_prg & 15);
        return (bank % (1 << (PRG_AW - 14))) * 16384 + int'(prg_a[13:0]);
    endfunction

    function automatic int exp_chr();
        int hi, c;
        hi = int'(chr_a[12]);
        if (m_ctrl & 16) c = hi ? m_chr1 : m_chr0;
        else             c = (m_chr0 & 30) | hi;
        return (c % (1 << (CHR_AW - 12))) * 4096 + int'(chr_a[11:0]);
    endfunction

    function automatic int exp_a10();
        case (m_ctrl & 3)
            0: return 0;
            1: return 1;
            2: return int'(chr_a[10]);
            default: return int'(chr_a[11]);
        endcase
    endfunction

    initial forever begin
        @(negedge clk);
        if (started) begin
            check("cmp_prg_rom_a", prg_rom_a, exp_prg());
            check("cmp_chr_rom_a", chr_rom_a, exp_chr());
            check("cmp_ciram_a10", ciram_a10, exp_a10());
            check("cmp_ciram_nce", ciram_nce, int'(!chr_a[13]));
            check("cmp_ram_en",    ram_en,    int'(((m_prg >> 4) & 1) == 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic go();
        @(posedge clk);
        #2;
    endtask

    // One bus write: strobe low for one cycle, then idle; period = gap + 2.
    task automatic wr(input logic [14:0] a, input logic [7:0] dat, input int gap);
        go();
        nce = 1'b0; rnw = 1'b0; prg_a = a; d = dat;
        go();
        nce = 1'b1; rnw = 1'b1;
        repeat (gap) @(posedge clk);
    endtask

    task automatic write5(input logic [14:0] a, input logic [4:0] val);
        for (int i = 0; i < 5; i++) wr(a, {7'd0, val[i]}, 4);
    endtask

    task automatic do_reset();
        go();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // 1: reset mapping
        go();
        prg_a = 15'h4000; chr_a = 14'h0000; #1;
        check("t1_prg_last_bank", prg_rom_a, 18'h3C000);
        prg_a = 15'h0000; #1;
        check("t1_prg_first", prg_rom_a, 18'h00000);
        check("t1_a10", ciram_a10, 1'b0);
        check("t1_ram_en", ram_en, 1'b1);
        check("t1_nce", ciram_nce, 1'b1);

        // 2: prg = 5
        write5(15'h6000, 5'd5);
        go();
        prg_a = 15'h0123; #1;
        check("t2_prg_bank5", prg_rom_a, 18'h14123);
        prg_a = 15'h4000; #1;
        check("t2_prg_fixed", prg_rom_a, 18'h3C000);

        // 3: ctrl = 12h, chr0 = 3, chr1 = 7
        write5(15'h0000, 5'h12);
        write5(15'h2000, 5'd3);
        write5(15'h4000, 5'd7);
        go();
        chr_a = 14'h0ABC; #1;
        check("t3_chr_lo", chr_rom_a, 17'h03ABC);
        check("t3_a10_0", ciram_a10, 1'b0);
        chr_a = 14'h1ABC; #1;
        check("t3_chr_hi", chr_rom_a, 17'h07ABC);
        chr_a = 14'h0EBC; #1;
        check("t3_a10_1", ciram_a10, 1'b1);
        prg_a = 15'h4000; #1;
        check("t3_prg_32k", prg_rom_a, 18'h14000);
        chr_a = 14'h2000; #1;
        check("t3_nce_low", ciram_nce, 1'b0);

        // 4: partial shift then reset write
        for (int i = 0; i < 3; i++) wr(15'h0000, 8'h01, 4);
        wr(15'h0000, 8'h80, 4);
        go();
        prg_a = 15'h4000; #1;
        check("t4_mode3", prg_rom_a, 18'h3C000);
        write5(15'h6000, 5'd2);
        go();
        prg_a = 15'h0123; #1;
        check("t4_prg2", prg_rom_a, 18'h08123);

        // 5: write hold-off
        do_reset();
        wr(15'h6000, 8'h01, 0);
        wr(15'h6000, 8'h01, 4);
        for (int i = 0; i < 4; i++) wr(15'h6000, 8'h00, 4);
        go();
        prg_a = 15'h0123; #1;
`ifdef MMC1_CONSEC_GUARD_EN
        check("t5_close_edges", prg_rom_a, 18'h04123);
`else
        check("t5_close_edges", prg_rom_a, 18'h0C123);
`endif
        wr(15'h0000, 8'h80, 4);
        wr(15'h6000, 8'h00, 3);
        wr(15'h6000, 8'h01, 3);
        for (int i = 0; i < 3; i++) wr(15'h6000, 8'h00, 3);
        go();
        prg_a = 15'h0123; #1;
        check("t5_far_edges", prg_rom_a, 18'h08123);

        // 6: PRG-RAM disable and reset mid-sequence
        write5(15'h6000, 5'h10);
        go();
        #1;
        check("t6_ram_dis", ram_en, 1'b0);
        wr(15'h6000, 8'h01, 4);
        wr(15'h6000, 8'h00, 4);
        do_reset();
        go();
        prg_a = 15'h4000; chr_a = 14'h1ABC; #1;
        check("t6_prg_last", prg_rom_a, 18'h3C000);
        check("t6_ram_en", ram_en, 1'b1);
        check("t6_chr_8k", chr_rom_a, 17'h01ABC);
        check("t6_a10", ciram_a10, 1'b0);
        write5(15'h6000, 5'd5);
        go();
        prg_a = 15'h0123; #1;
        check("t6_after_reset", prg_rom_a, 18'h14123);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
